// File: rtl/ysyx_25020037_ifu_refill_pkg.sv
// Shared types and constants for the IFU and its I-cache refill engine.
// FSM encodings, AXI4 field values and the IFU->IDU bus layout.
package ysyx_25020037_ifu_refill_pkg;

  typedef enum logic [2:0] {
    StLookup   = 3'd0,
    StAr       = 3'd1,
    StRdata    = 3'd2,
    StWaitFill = 3'd3,
    StHold     = 3'd4
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ifu_idu_t;

  localparam int unsigned IFU_IDU_W = $bits(ifu_idu_t);

  function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned words);
    logic [31:0] mask;
    mask = 32'(words * 4) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/ysyx_25020037_ifu_refill_if.sv
// AXI4 read-address / read-data channels between the IFU refill engine and memory.
interface ysyx_25020037_ifu_refill_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/ysyx_25020037_line_buf.sv
// Refill line assembly: beat counter, per-word capture, sticky error and done detection.
module ysyx_25020037_line_buf
  import ysyx_25020037_ifu_refill_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     beat_i,
  input  logic                     burst_i,
  input  logic [31:0]              rdata_i,
  input  logic [1:0]               rresp_i,
  input  logic                     rlast_i,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     err_now_o,
  output logic [32*BLOCK_WORDS-1:0] line_o
);

  localparam int unsigned CntW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     words_q [BLOCK_WORDS];
  logic            last_beat;

  assign last_beat = (cnt_q == CntW'(BLOCK_WORDS - 1));
  assign err_now_o = err_q | (beat_i && (rresp_i != RESP_OKAY));
  // Burst lines end on rlast; single-beat lines end after BLOCK_WORDS beats.
  assign done_o    = beat_i && (burst_i ? rlast_i : last_beat);
  assign err_o     = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear_i) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (beat_i) begin
      err_d = err_now_o;
      if (!last_beat) cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < int'(BLOCK_WORDS); i++) words_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (beat_i && !clear_i) words_q[cnt_q] <= rdata_i;
    end
  end

  always_comb begin
    line_o = '0;
    for (int i = 0; i < int'(BLOCK_WORDS); i++) line_o[32*i +: 32] = words_q[i];
  end

endmodule

// File: rtl/ysyx_25020037_ifu_refill.sv
// Instruction fetch unit with I-cache lookup, AXI4 line refill and registered IDU output.
// Define YSYX_25020037_IFU_PERF_EN to add the hit/miss/stall performance counters.
module ysyx_25020037_ifu_refill
  import ysyx_25020037_ifu_refill_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = 4,
  parameter logic [31:0] RESET_PC    = 32'h3000_0000,
  parameter logic [31:0] BURST_BASE  = 32'hA000_0000,
  parameter logic [31:0] BURST_END   = 32'hBFFF_FFFF,
  parameter logic [3:0]  AXI_ID      = 4'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      ifu_valid,
  input  logic                      idu_ready,
  output logic [31:0]               ifu_pc,
  output logic [31:0]               ifu_inst,
  output logic                      ifu_fault,
  output logic [31:0]               icache_addr,
  input  logic                      icache_hit,
  input  logic [31:0]               icache_data,
  output logic                      refill_valid,
  output logic [31:0]               refill_addr,
  output logic [32*BLOCK_WORDS-1:0] refill_data,
`ifdef YSYX_25020037_IFU_PERF_EN
  output logic [31:0]               perf_hit,
  output logic [31:0]               perf_miss,
  output logic [31:0]               perf_stall,
`endif
  ysyx_25020037_ifu_refill_if.master axi
);

  state_e         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  ifu_idu_t       out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic           arvalid_q, arvalid_d;
  logic [31:0]    araddr_q, araddr_d;
  logic [7:0]     arlen_q, arlen_d;
  logic [1:0]     arburst_q, arburst_d;
  logic           rready_q, rready_d;
  logic           refill_valid_q, refill_valid_d;
  logic [31:0]    base_q, base_d;
  logic           burst_q, burst_d;
  logic           pending_q, pending_d;

  logic           slot_free, beat, lb_clear, lb_done, lb_err, lb_err_now;
  logic [31:0]    miss_base;
  logic           miss_burst;
  logic [IFU_IDU_W-1:0] out_bus;

  assign slot_free  = !out_valid_q || idu_ready;
  assign miss_base  = line_base(pc_q, BLOCK_WORDS);
  assign miss_burst = (miss_base >= BURST_BASE) && (miss_base <= BURST_END);
  // Beats with a foreign rid are not ours and are simply not counted.
  assign beat = (state_q == StRdata) && rready_q && axi.rvalid && (axi.rid == AXI_ID);

  ysyx_25020037_line_buf #(
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (lb_clear),
    .beat_i    (beat),
    .burst_i   (burst_q),
    .rdata_i   (axi.rdata),
    .rresp_i   (axi.rresp),
    .rlast_i   (axi.rlast),
    .done_o    (lb_done),
    .err_o     (lb_err),
    .err_now_o (lb_err_now),
    .line_o    (refill_data)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    out_d          = out_q;
    out_valid_d    = out_valid_q && !idu_ready;
    arvalid_d      = arvalid_q;
    araddr_d       = araddr_q;
    arlen_d        = arlen_q;
    arburst_d      = arburst_q;
    rready_d       = rready_q;
    refill_valid_d = 1'b0;
    base_d         = base_q;
    burst_d        = burst_q;
    pending_d      = pending_q;
    lb_clear       = 1'b0;

    unique case (state_q)
      StLookup: begin
        if (!redirect_valid && slot_free) begin
          if (icache_hit) begin
            out_valid_d = 1'b1;
            out_d       = '{pc: pc_q, inst: icache_data, fault: 1'b0};
            pc_d        = pc_q + 32'd4;
          end else begin
            state_d   = StAr;
            arvalid_d = 1'b1;
            araddr_d  = miss_base;
            arlen_d   = miss_burst ? 8'(BLOCK_WORDS - 1) : 8'd0;
            arburst_d = miss_burst ? BURST_INCR : BURST_FIXED;
            base_d    = miss_base;
            burst_d   = miss_burst;
            pending_d = 1'b0;
            lb_clear  = 1'b1;
          end
        end
      end
      StAr: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        if (beat) begin
          if (lb_done) begin
            rready_d       = 1'b0;
            refill_valid_d = !lb_err_now;
            state_d        = StWaitFill;
          end else if (!burst_q) begin
            rready_d  = 1'b0;
            arvalid_d = 1'b1;
            araddr_d  = araddr_q + 32'd4;
            state_d   = StAr;
          end
        end
      end
      StWaitFill: begin
        // A redirect seen during the miss restarts fetch instead of reporting the fault.
        if (lb_err && !pending_q && !redirect_valid) begin
          out_valid_d = 1'b1;
          out_d       = '{pc: pc_q, inst: 32'd0, fault: 1'b1};
          state_d     = StHold;
        end else begin
          state_d = StLookup;
        end
      end
      StHold: begin
        if (redirect_valid) state_d = StLookup;
      end
      default: state_d = StLookup;
    endcase

    if (redirect_valid) begin
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      if (state_q inside {StAr, StRdata, StWaitFill}) pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StLookup;
      pc_q           <= RESET_PC;
      out_q          <= '0;
      out_valid_q    <= 1'b0;
      arvalid_q      <= 1'b0;
      araddr_q       <= '0;
      arlen_q        <= '0;
      arburst_q      <= BURST_FIXED;
      rready_q       <= 1'b0;
      refill_valid_q <= 1'b0;
      base_q         <= '0;
      burst_q        <= 1'b0;
      pending_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      out_q          <= out_d;
      out_valid_q    <= out_valid_d;
      arvalid_q      <= arvalid_d;
      araddr_q       <= araddr_d;
      arlen_q        <= arlen_d;
      arburst_q      <= arburst_d;
      rready_q       <= rready_d;
      refill_valid_q <= refill_valid_d;
      base_q         <= base_d;
      burst_q        <= burst_d;
      pending_q      <= pending_d;
    end
  end

  assign out_bus                       = out_q;
  assign {ifu_pc, ifu_inst, ifu_fault} = out_bus;
  assign ifu_valid                     = out_valid_q;
  assign icache_addr                   = pc_q;
  assign refill_valid                  = refill_valid_q;
  assign refill_addr                   = base_q;

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arid    = AXI_ID;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = SIZE_4B;
  assign axi.arburst = arburst_q;
  assign axi.rready  = rready_q;

`ifdef YSYX_25020037_IFU_PERF_EN
  logic        hit_take, miss_take, stall_cyc;
  logic [31:0] perf_hit_q, perf_miss_q, perf_stall_q;

  assign hit_take  = (state_q == StLookup) && !redirect_valid && slot_free && icache_hit;
  assign miss_take = (state_q == StLookup) && !redirect_valid && slot_free && !icache_hit;
  assign stall_cyc = state_q inside {StAr, StRdata, StWaitFill};

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_hit_q   <= '0;
      perf_miss_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (hit_take)  perf_hit_q   <= perf_hit_q + 32'd1;
      if (miss_take) perf_miss_q  <= perf_miss_q + 32'd1;
      if (stall_cyc) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_hit   = perf_hit_q;
  assign perf_miss  = perf_miss_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_25020037_ifu_refill.sv
// Directed bench for the IFU refill engine: table-driven hit stream plus miss/redirect/error
// sequences, with a small I-cache model and an AXI4 read slave.
module tb_ysyx_25020037_ifu_refill;

  logic         clk = 1'b0;
  logic         rst;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         ifu_valid, idu_ready, ifu_fault;
  logic [31:0]  ifu_pc, ifu_inst, icache_addr, icache_data, refill_addr;
  logic         icache_hit, refill_valid;
  logic [127:0] refill_data;
`ifdef YSYX_25020037_IFU_PERF_EN
  logic [31:0]  perf_hit, perf_miss, perf_stall;
`endif

  ysyx_25020037_ifu_refill_if axi_if ();

  ysyx_25020037_ifu_refill dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifu_valid      (ifu_valid),
    .idu_ready      (idu_ready),
    .ifu_pc         (ifu_pc),
    .ifu_inst       (ifu_inst),
    .ifu_fault      (ifu_fault),
    .icache_addr    (icache_addr),
    .icache_hit     (icache_hit),
    .icache_data    (icache_data),
    .refill_valid   (refill_valid),
    .refill_addr    (refill_addr),
    .refill_data    (refill_data),
`ifdef YSYX_25020037_IFU_PERF_EN
    .perf_hit       (perf_hit),
    .perf_miss      (perf_miss),
    .perf_stall     (perf_stall),
`endif
    .axi            (axi_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    return {mw(base + 32'hC), mw(base + 32'h8), mw(base + 32'h4), mw(base)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // I-cache model: two preloaded lines, later lines captured from refill writes.
  logic [31:0]  c_tag  [8];
  logic         c_vld  [8];
  logic [127:0] c_data [8];
  int           c_ptr;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) c_vld[i] <= 1'b0;
      c_vld[0]  <= 1'b1;
      c_tag[0]  <= 32'h3000_0000;
      c_data[0] <= {line_of(32'h3000_0000) >> 32, 32'h0000_0413};
      c_vld[1]  <= 1'b1;
      c_tag[1]  <= 32'h3000_0100;
      c_data[1] <= line_of(32'h3000_0100);
      c_ptr     <= 2;
    end else if (refill_valid) begin
      c_vld[c_ptr]  <= 1'b1;
      c_tag[c_ptr]  <= refill_addr;
      c_data[c_ptr] <= refill_data;
      c_ptr         <= (c_ptr + 1) % 8;
    end
  end

  always_comb begin
    icache_hit  = 1'b0;
    icache_data = 32'd0;
    for (int i = 0; i < 8; i++) begin
      if (c_vld[i] === 1'b1 && c_tag[i] == {icache_addr[31:4], 4'h0}) begin
        icache_hit  = 1'b1;
        icache_data = c_data[i][32*icache_addr[3:2] +: 32];
      end
    end
  end

  // AXI4 read slave: optional AR wait, one beat per cycle, optional error beat.
  int          ar_delay   = 0;
  int          err_beat   = -1;
  int          beats_seen = 0;
  logic [31:0] ar_addr_q  [$];
  logic [7:0]  ar_len_q   [$];
  logic [1:0]  ar_burst_q [$];

  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    axi_if.rdata   = 32'd0;
    axi_if.rresp   = 2'b00;
    axi_if.rlast   = 1'b0;
    axi_if.rid     = 4'h0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && axi_if.arvalid === 1'b1) begin
        for (int w = 0; w < ar_delay; w++) @(negedge clk);
        axi_if.arready = 1'b1;
        @(posedge clk);
        addr = axi_if.araddr;
        len  = axi_if.arlen;
        ar_addr_q.push_back(addr);
        ar_len_q.push_back(len);
        ar_burst_q.push_back(axi_if.arburst);
        @(negedge clk);
        axi_if.arready = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
          axi_if.rvalid = 1'b1;
          axi_if.rdata  = mw(addr + 32'(4 * b));
          axi_if.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
          axi_if.rlast  = (b == int'(len));
          do @(posedge clk); while (axi_if.rready !== 1'b1);
          beats_seen++;
          @(negedge clk);
        end
        axi_if.rvalid = 1'b0;
        axi_if.rlast  = 1'b0;
        axi_if.rresp  = 2'b00;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_addr;
    logic        exp_arvalid;
  } vec_t;

  vec_t vecs [10];

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic saw_valid, saw_refill;

    for (int i = 0; i < 5; i++)
      vecs[i] = '{1'b0, 1'b1, 32'h3000_0000, 32'h0000_0413, 32'h3000_0004, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h3000_0004, mw(32'h3000_0004), 32'h3000_0008, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'h3000_0008, mw(32'h3000_0008), 32'h3000_000C, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'h3000_0008, mw(32'h3000_0008), 32'h3000_000C, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 32'h3000_000C, mw(32'h3000_000C), 32'h3000_0010, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 32'h0,         32'h0,             32'h3000_0010, 1'b1};

    rst            = 1'b0;
    idu_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_icache_addr", icache_addr, 32'h3000_0000);
    chk("rst_ifu_valid", ifu_valid, 1'b0);
    chk("rst_ifu_fault", ifu_fault, 1'b0);
    chk("rst_refill_valid", refill_valid, 1'b0);
    chk("rst_arvalid", axi_if.arvalid, 1'b0);
    chk("rst_rready", axi_if.rready, 1'b0);
    chk("rst_ifu_pc", ifu_pc, 32'd0);
    chk("rst_ifu_inst", ifu_inst, 32'd0);
    chk("rst_araddr", axi_if.araddr, 32'd0);
    chk("rst_arlen", axi_if.arlen, 8'd0);
    chk("rst_arsize", axi_if.arsize, 3'b010);
    chk("rst_arburst", axi_if.arburst, 2'b00);
    chk("rst_arid", axi_if.arid, 4'h0);
    chk("rst_refill_data", refill_data, 128'd0);
    rst = 1'b1;

    // First hit delivered one cycle after reset release
    @(negedge clk);
    chk("t1_valid", ifu_valid, 1'b1);
    chk("t1_pc", ifu_pc, 32'h3000_0000);
    chk("t1_inst", ifu_inst, 32'h0000_0413);

    // Backpressure, hit stream and the miss at the end of the preloaded line
    for (int i = 0; i < 10; i++) begin
      idu_ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), ifu_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_pc", i), ifu_pc, vecs[i].exp_pc);
        chk($sformatf("vec%0d_inst", i), ifu_inst, vecs[i].exp_inst);
      end
      chk($sformatf("vec%0d_addr", i), icache_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_arvalid", i), axi_if.arvalid, vecs[i].exp_arvalid);
    end
    idu_ready = 1'b0;

    // Single-beat region: four separate ARs for the 30000010 line
    for (int c = 0; c < 200; c++) begin
      if (refill_valid) break;
      @(negedge clk);
    end
    chk("t3_refill_seen", refill_valid, 1'b1);
    chk("t3_refill_addr", refill_addr, 32'h3000_0010);
    chk("t3_refill_data", refill_data, line_of(32'h3000_0010));
    chk("t3_ar_count", ar_addr_q.size(), 4);
    for (int k = 0; k < 4 && k < ar_addr_q.size(); k++) begin
      chk($sformatf("t3_ar%0d_addr", k), ar_addr_q[k], 32'h3000_0010 + 32'(4 * k));
      chk($sformatf("t3_ar%0d_len", k), ar_len_q[k], 8'd0);
      chk($sformatf("t3_ar%0d_burst", k), ar_burst_q[k], 2'b00);
    end
    for (int c = 0; c < 20; c++) begin
      if (ifu_valid) break;
      @(negedge clk);
    end
    chk("t3_hit_valid", ifu_valid, 1'b1);
    chk("t3_hit_pc", ifu_pc, 32'h3000_0010);
    chk("t3_hit_inst", ifu_inst, mw(32'h3000_0010));

    // Burst region miss with a slow arready
    ar_addr_q.delete(); ar_len_q.delete(); ar_burst_q.delete();
    ar_delay = 2;
    pulse_redirect(32'hA000_0008);
    chk("t2_killed", ifu_valid, 1'b0);
    chk("t2_addr", icache_addr, 32'hA000_0008);
    @(negedge clk);
    chk("t2_arvalid", axi_if.arvalid, 1'b1);
    chk("t2_araddr", axi_if.araddr, 32'hA000_0000);
    chk("t2_arlen", axi_if.arlen, 8'd3);
    chk("t2_arburst", axi_if.arburst, 2'b01);
    @(negedge clk);
    chk("t2_arvalid_held", axi_if.arvalid, 1'b1);
    chk("t2_araddr_held", axi_if.araddr, 32'hA000_0000);
    for (int c = 0; c < 200; c++) begin
      if (refill_valid) break;
      @(negedge clk);
    end
    chk("t2_refill_seen", refill_valid, 1'b1);
    chk("t2_refill_addr", refill_addr, 32'hA000_0000);
    chk("t2_word2", refill_data[95:64], mw(32'hA000_0008));
    chk("t2_refill_data", refill_data, line_of(32'hA000_0000));
    chk("t2_ar_count", ar_addr_q.size(), 1);
    for (int c = 0; c < 20; c++) begin
      if (ifu_valid) break;
      @(negedge clk);
    end
    chk("t2_hit_pc", ifu_pc, 32'hA000_0008);
    chk("t2_hit_inst", ifu_inst, mw(32'hA000_0008));
    ar_delay = 0;

    // Redirect during beat 1: burst drains, line written, fetch restarts at new pc
    pulse_redirect(32'hA000_0040);
    for (int c = 0; c < 50; c++) begin
      if (axi_if.rready) break;
      @(negedge clk);
    end
    chk("t4_rready", axi_if.rready, 1'b1);
    @(negedge clk);
    pulse_redirect(32'h3000_0100);
    chk("t4_new_addr", icache_addr, 32'h3000_0100);
    saw_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      saw_valid |= ifu_valid;
      if (refill_valid) break;
      @(negedge clk);
    end
    chk("t4_refill_seen", refill_valid, 1'b1);
    chk("t4_refill_addr", refill_addr, 32'hA000_0040);
    chk("t4_refill_data", refill_data, line_of(32'hA000_0040));
    chk("t4_no_stale_valid", saw_valid, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (ifu_valid) break;
      @(negedge clk);
    end
    chk("t4_hit_pc", ifu_pc, 32'h3000_0100);
    chk("t4_hit_inst", ifu_inst, mw(32'h3000_0100));

    // Error on beat 2: drained, no refill, fault delivered, then HOLD
    err_beat   = 2;
    beats_seen = 0;
    pulse_redirect(32'hA000_0080);
    saw_refill = 1'b0;
    for (int c = 0; c < 100; c++) begin
      saw_refill |= refill_valid;
      if (ifu_valid) break;
      @(negedge clk);
    end
    chk("t5_valid", ifu_valid, 1'b1);
    chk("t5_fault", ifu_fault, 1'b1);
    chk("t5_inst", ifu_inst, 32'd0);
    chk("t5_pc", ifu_pc, 32'hA000_0080);
    chk("t5_no_refill", saw_refill, 1'b0);
    chk("t5_beats", beats_seen, 4);
    @(negedge clk);
    chk("t5_fault_stable", {ifu_valid, ifu_fault}, 2'b11);
    idu_ready = 1'b1;
    @(negedge clk);
    chk("t5_taken", ifu_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_hold_valid", ifu_valid, 1'b0);
    chk("t5_hold_arvalid", axi_if.arvalid, 1'b0);
    chk("t5_hold_addr", icache_addr, 32'hA000_0080);
    err_beat = -1;
    pulse_redirect(32'h3000_0000);
    @(negedge clk);
    chk("t5_resume_valid", ifu_valid, 1'b1);
    chk("t5_resume_pc", ifu_pc, 32'h3000_0000);
    chk("t5_resume_inst", ifu_inst, 32'h0000_0413);

    // Redirect together with an accepted output and a same-cycle hit: hit discarded
    pulse_redirect(32'h3000_0100);
    chk("t6_hit_dropped", ifu_valid, 1'b0);
    chk("t6_addr", icache_addr, 32'h3000_0100);
    @(negedge clk);
    chk("t6_valid", ifu_valid, 1'b1);
    chk("t6_pc", ifu_pc, 32'h3000_0100);
    idu_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
